// File: rtl/tdoa_collector.sv
// tdoa_collector
//   Gathers one acoustic event from N_CH threshold detectors and packages the
//   arrival times as differences against the earliest-latched channel.
//
//   Ports:
//     clk          system clock, rising edge
//     rst          asynchronous active-high reset
//     ch_valid     per-channel detection valid, held by detector until acked
//     ch_time      packed detect times, channel i at [i*TW +: TW]
//     ch_ack       one-cycle acknowledge, the cycle after the channel latches
//     out_valid    result bundle valid, held until out_ack
//     out_ack      consumer acknowledge
//     out_mask     channels that arrived within the window
//     out_ref      index of the reference (earliest-latched) channel
//     out_diff     packed ch_time[i] - ref_time, modulo 2^TW
//     out_timeout  event closed by window expiry rather than full arrival
module tdoa_collector #(
    parameter int N_CH   = 4,
    parameter int TW     = 32,
    parameter int WINDOW = 4096
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_CH-1:0]      ch_valid,
    input  logic [N_CH*TW-1:0]   ch_time,
    output logic [N_CH-1:0]      ch_ack,
    output logic                 out_valid,
    input  logic                 out_ack,
    output logic [N_CH-1:0]      out_mask,
    output logic [2:0]           out_ref,
    output logic [N_CH*TW-1:0]   out_diff,
    output logic                 out_timeout
);

    localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t            state_r;
    logic [N_CH-1:0]   got_r;
    logic [TW-1:0]     time_r [N_CH];
    logic [2:0]        ref_r;
    logic [CW-1:0]     cnt_r;

    logic [N_CH-1:0]   latch_s;
    logic [N_CH-1:0]   got_next_s;
    logic              all_got_s;
    logic [TW-1:0]     time_next_s [N_CH];
    logic [2:0]        ref_next_s;
    logic [TW-1:0]     ref_time_s;
    logic [N_CH*TW-1:0] diff_s;
    logic              enter_done_s;
    logic              timeout_s;

    // Lowest set bit index; used to pick the reference among simultaneous arrivals.
    function automatic logic [2:0] lowest_set(input logic [N_CH-1:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Latch qualification and the view of got/time/reference after this edge.
    always_comb begin
        latch_s = '0;
        if (state_r != ST_DONE) begin
            latch_s = ch_valid & ~got_r;
        end else begin
            latch_s = '0;
        end
        got_next_s = got_r | latch_s;
        all_got_s  = &got_next_s;
        for (int i = 0; i < N_CH; i++) begin
            time_next_s[i] = latch_s[i] ? ch_time[i*TW +: TW] : time_r[i];
        end
        if (state_r == ST_IDLE) begin
            ref_next_s = lowest_set(latch_s);
        end else begin
            ref_next_s = ref_r;
        end
    end

    // Differences against the reference; includes channels latching on this edge.
    always_comb begin
        ref_time_s = '0;
        diff_s     = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (3'(i) == ref_next_s) begin
                ref_time_s = time_next_s[i];
            end else begin
                ref_time_s = ref_time_s;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (got_next_s[i] && (3'(i) != ref_next_s)) begin
                diff_s[i*TW +: TW] = time_next_s[i] - ref_time_s;
            end else begin
                diff_s[i*TW +: TW] = '0;
            end
        end
    end

    // Event close decision: full arrival wins over expiry on the same edge.
    always_comb begin
        enter_done_s = 1'b0;
        timeout_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (all_got_s) begin
                    enter_done_s = 1'b1;
                end else begin
                    enter_done_s = 1'b0;
                end
            end
            ST_COLLECT: begin
                if (all_got_s) begin
                    enter_done_s = 1'b1;
                end else if (cnt_r == CNT_LAST) begin
                    enter_done_s = 1'b1;
                    timeout_s    = 1'b1;
                end else begin
                    enter_done_s = 1'b0;
                end
            end
            default: begin
                enter_done_s = 1'b0;
                timeout_s    = 1'b0;
            end
        endcase
    end

    // State, latches, window counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            got_r       <= '0;
            ref_r       <= 3'd0;
            cnt_r       <= '0;
            for (int i = 0; i < N_CH; i++) begin
                time_r[i] <= '0;
            end
            ch_ack      <= '0;
            out_valid   <= 1'b0;
            out_mask    <= '0;
            out_ref     <= 3'd0;
            out_diff    <= '0;
            out_timeout <= 1'b0;
        end else begin
            ch_ack <= latch_s;
            got_r  <= got_next_s;
            for (int i = 0; i < N_CH; i++) begin
                time_r[i] <= time_next_s[i];
            end
            if (enter_done_s) begin
                state_r     <= ST_DONE;
                out_valid   <= 1'b1;
                out_mask    <= got_next_s;
                out_ref     <= ref_next_s;
                out_diff    <= diff_s;
                out_timeout <= timeout_s;
            end
            case (state_r)
                ST_IDLE: begin
                    if (|latch_s) begin
                        ref_r <= ref_next_s;
                        cnt_r <= '0;
                        if (!enter_done_s) begin
                            state_r <= ST_COLLECT;
                        end
                    end
                end
                ST_COLLECT: begin
                    cnt_r <= cnt_r + CW'(1);
                end
                ST_DONE: begin
                    // Bundle stays frozen; only the consumer ack releases it.
                    if (out_ack) begin
                        out_valid <= 1'b0;
                        got_r     <= '0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
